// File: rtl/render_pkg.sv
// Shared types and constants for the frame transform sequencer.
// Covers the FSM state encoding, the trig result tags and angle handling.
package render_pkg;

  localparam int                 ANGLE_W = 12;
  localparam logic [ANGLE_W-1:0] TWO_PI  = 12'h648;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIG  = 2'd1,
    ISSUE = 2'd2,
    DRAIN = 2'd3
  } xf_state_t;

  typedef enum logic [1:0] {
    TAG_A = 2'd0,
    TAG_B = 2'd1,
    TAG_G = 2'd2
  } trig_tag_t;

  // Two conditional subtractions bring any 12-bit code below 2*pi, so a
  // stray out-of-range angle never reaches the LUT.
  function automatic logic [ANGLE_W-1:0] wrap_angle(input logic [ANGLE_W-1:0] a);
    logic [ANGLE_W-1:0] r;
    r = a;
    if (r >= TWO_PI) r = r - TWO_PI;
    if (r >= TWO_PI) r = r - TWO_PI;
    return r;
  endfunction

endpackage

// File: rtl/xform_sequencer_trig_tag_pipe.sv
// Delay line that carries a valid bit and an angle tag alongside the trig LUT,
// so each sin/cos result is routed to the angle that requested it.
module trig_tag_pipe
  import render_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic      Clk,
  input  logic      Reset,
  input  logic      valid_i,
  input  trig_tag_t tag_i,
  output logic      valid_o,
  output trig_tag_t tag_o
);

  logic [LAT-1:0] valid_q;
  trig_tag_t      tag_q [LAT];

  // NOTE: every stage is reset, tags included; a stale valid bit left over
  // from an aborted frame would otherwise overwrite a latched sin/cos pair.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= TAG_A;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign tag_o   = tag_q[LAT-1];

endmodule

// File: rtl/xform_sequencer.sv
// Per-frame scheduler: snapshots the pose on a frame tick, evaluates six trig
// values through one shared LUT port, then streams vertex indices to the transform unit.
module xform_sequencer
  import render_pkg::*;
#(
  parameter int WI        = 8,
  parameter int WF        = 8,
  parameter int TW        = 16,
  parameter int NUM_VERTS = 64,
  parameter int VW        = 6,
  parameter int TRIG_LAT  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk_rising_edge,
  input  logic [ANGLE_W-1:0] alpha,
  input  logic [ANGLE_W-1:0] beta,
  input  logic [ANGLE_W-1:0] gamma,
  input  logic [WI+WF-1:0]   x,
  input  logic [WI+WF-1:0]   y,
  input  logic [WI+WF-1:0]   z,
  output logic [ANGLE_W-1:0] trig_angle,
  input  logic [TW-1:0]      trig_sin,
  input  logic [TW-1:0]      trig_cos,
  output logic [TW-1:0]      sin_a,
  output logic [TW-1:0]      cos_a,
  output logic [TW-1:0]      sin_b,
  output logic [TW-1:0]      cos_b,
  output logic [TW-1:0]      sin_g,
  output logic [TW-1:0]      cos_g,
  output logic [WI+WF-1:0]   px,
  output logic [WI+WF-1:0]   py,
  output logic [WI+WF-1:0]   pz,
  output logic               xf_valid,
  input  logic               xf_ready,
  output logic [VW-1:0]      xf_index,
  input  logic               xf_done,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam int             TCW       = $clog2(TRIG_LAT + 3);
  localparam logic [TCW-1:0] TRIG_LAST = TCW'(TRIG_LAT + 2);
  localparam logic [VW-1:0]  IDX_LAST  = VW'(NUM_VERTS - 1);
  localparam logic [VW:0]    CNT_FULL  = (VW+1)'(NUM_VERTS);

  xf_state_t          state_q, state_d;
  logic [TCW-1:0]     trig_cnt_q, trig_cnt_d;
  logic [VW-1:0]      idx_q, idx_d;
  logic [VW:0]        cnt_q, cnt_d;
  logic [ANGLE_W-1:0] alpha_q, beta_q, gamma_q;
  logic [WI+WF-1:0]   px_q, py_q, pz_q;
  logic [TW-1:0]      sin_a_q, cos_a_q, sin_b_q, cos_b_q, sin_g_q, cos_g_q;
  logic               overrun_q;

  logic        xfer, done_now, snap;
  logic [VW:0] cnt_inc;
  logic        tag_valid_in, tag_valid_out;
  trig_tag_t   tag_in, tag_out;

  // Completion count including this cycle's xf_done, so the last completion
  // and frame_done land in the same cycle.
  assign cnt_inc  = cnt_q + {{VW{1'b0}}, xf_done};
  assign xfer     = (state_q == ISSUE) && xf_ready;
  assign done_now = (state_q == DRAIN) && (cnt_inc == CNT_FULL);
  assign snap     = frame_clk_rising_edge && ((state_q == IDLE) || done_now);

  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = '0;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (snap) state_d = TRIG;
      end
      TRIG: begin
        if (trig_cnt_q == TRIG_LAST) begin
          state_d = ISSUE;
          idx_d   = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + TCW'(1);
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (xfer) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + VW'(1);
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (done_now) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = snap ? TRIG : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first three TRIG cycles present the snapshot angles; the rest wait out the LUT latency.
  always_comb begin
    trig_angle   = '0;
    tag_valid_in = 1'b0;
    tag_in       = TAG_A;
    if (state_q == TRIG) begin
      if (trig_cnt_q == TCW'(0)) begin
        trig_angle   = alpha_q;
        tag_valid_in = 1'b1;
        tag_in       = TAG_A;
      end else if (trig_cnt_q == TCW'(1)) begin
        trig_angle   = beta_q;
        tag_valid_in = 1'b1;
        tag_in       = TAG_B;
      end else if (trig_cnt_q == TCW'(2)) begin
        trig_angle   = gamma_q;
        tag_valid_in = 1'b1;
        tag_in       = TAG_G;
      end
    end
  end

  trig_tag_pipe #(
    .LAT (TRIG_LAT)
  ) u_tag_pipe (
    .Clk     (Clk),
    .Reset   (Reset),
    .valid_i (tag_valid_in),
    .tag_i   (tag_in),
    .valid_o (tag_valid_out),
    .tag_o   (tag_out)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they stood before the clock edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      if (frame_clk_rising_edge && (state_q != IDLE) && !done_now) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      alpha_q <= '0;
      beta_q  <= '0;
      gamma_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pz_q    <= '0;
    end else if (snap) begin
      alpha_q <= wrap_angle(alpha);
      beta_q  <= wrap_angle(beta);
      gamma_q <= wrap_angle(gamma);
      px_q    <= x;
      py_q    <= y;
      pz_q    <= z;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sin_a_q <= '0;
      cos_a_q <= '0;
      sin_b_q <= '0;
      cos_b_q <= '0;
      sin_g_q <= '0;
      cos_g_q <= '0;
    end else if (tag_valid_out) begin
      unique case (tag_out)
        TAG_A: begin sin_a_q <= trig_sin; cos_a_q <= trig_cos; end
        TAG_B: begin sin_b_q <= trig_sin; cos_b_q <= trig_cos; end
        TAG_G: begin sin_g_q <= trig_sin; cos_g_q <= trig_cos; end
        default: ;
      endcase
    end
  end

  assign sin_a      = sin_a_q;
  assign cos_a      = cos_a_q;
  assign sin_b      = sin_b_q;
  assign cos_b      = cos_b_q;
  assign sin_g      = sin_g_q;
  assign cos_g      = cos_g_q;
  assign px         = px_q;
  assign py         = py_q;
  assign pz         = pz_q;
  assign xf_valid   = (state_q == ISSUE);
  assign xf_index   = idx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_now;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_xform_sequencer.sv
// Directed-plus-random bench for xform_sequencer with a behavioural trig LUT,
// a transform-unit responder and an in-order vertex scoreboard.
module tb_xform_sequencer;

  localparam int NV  = 4;
  localparam int VWB = 2;
  localparam int LAT = 2;
  localparam int FIRST_VALID = 3 + LAT + 1;

  typedef struct {
    logic [11:0] a, b, g;
    logic [15:0] x, y, z;
  } pose_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        tick = 1'b0;
  logic [11:0] alpha = '0, beta = '0, gamma = '0;
  logic [15:0] x = '0, y = '0, z = '0;
  logic [11:0] trig_angle;
  logic [15:0] trig_sin, trig_cos;
  logic [15:0] sin_a, cos_a, sin_b, cos_b, sin_g, cos_g;
  logic [15:0] px, py, pz;
  logic        xf_valid, xf_ready = 1'b1, xf_done = 1'b0;
  logic [VWB-1:0] xf_index;
  logic        busy, frame_done, overrun;

  int n_total = 0, n_pass = 0, n_fail = 0;
  int fd_count = 0;
  int got_q[$];
  bit rand_ready = 1'b0;
  logic [2:0] done_sh = '0;
  bit hold_pend = 1'b0;
  logic [VWB-1:0] hold_idx = '0;
  logic [11:0] lut_d [LAT];

  xform_sequencer #(
    .WI(8), .WF(8), .TW(16), .NUM_VERTS(NV), .VW(VWB), .TRIG_LAT(LAT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(tick),
    .alpha(alpha), .beta(beta), .gamma(gamma), .x(x), .y(y), .z(z),
    .trig_angle(trig_angle), .trig_sin(trig_sin), .trig_cos(trig_cos),
    .sin_a(sin_a), .cos_a(cos_a), .sin_b(sin_b), .cos_b(cos_b), .sin_g(sin_g), .cos_g(cos_g),
    .px(px), .py(py), .pz(pz),
    .xf_valid(xf_valid), .xf_ready(xf_ready), .xf_index(xf_index), .xf_done(xf_done),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Trig LUT stand-in: a fixed distinct mapping per angle, LAT cycles late.
  function automatic logic [15:0] f_sin(input logic [11:0] a);
    return {a, 4'hA} ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] f_cos(input logic [11:0] a);
    return {4'h3, a} + 16'h0101;
  endfunction

  initial for (int i = 0; i < LAT; i++) lut_d[i] = '0;
  always @(posedge Clk) begin
    lut_d[0] <= trig_angle;
    for (int i = 1; i < LAT; i++) lut_d[i] <= lut_d[i-1];
  end
  assign trig_sin = f_sin(lut_d[LAT-1]);
  assign trig_cos = f_cos(lut_d[LAT-1]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transform-unit responder: drives xf_ready/xf_done just after each edge,
  // completes each accepted vertex two cycles later, and checks handshake holds.
  always begin
    @(posedge Clk); #1;
    done_sh  = done_sh >> 1;
    xf_done  = done_sh[0];
    xf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge Clk);
    if (Reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(xf_valid), 32'd1);
        check("hold_index", 32'(xf_index), 32'(hold_idx));
      end
      hold_pend = xf_valid && !xf_ready;
      hold_idx  = xf_index;
      if (xf_valid && xf_ready) begin
        got_q.push_back(int'(xf_index));
        done_sh[2] = 1'b1;
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask
  task automatic observe();
    @(negedge Clk);
  endtask

  function automatic pose_t rand_pose();
    pose_t p;
    p.a = 12'($urandom_range(0, 12'h647));
    p.b = 12'($urandom_range(0, 12'h647));
    p.g = 12'($urandom_range(0, 12'h647));
    p.x = 16'($urandom);
    p.y = 16'($urandom);
    p.z = 16'($urandom);
    return p;
  endfunction

  task automatic apply_pose(input pose_t p);
    alpha = p.a; beta = p.b; gamma = p.g; x = p.x; y = p.y; z = p.z;
  endtask

  // Leaves the bench at the negedge of the tick cycle (cycle 0).
  task automatic do_tick(input pose_t p);
    step();
    apply_pose(p);
    tick = 1'b1;
    observe();
  endtask

  task automatic check_pose(input string tag, input pose_t p);
    check({tag, "_px"}, 32'(px), 32'(p.x));
    check({tag, "_py"}, 32'(py), 32'(p.y));
    check({tag, "_pz"}, 32'(pz), 32'(p.z));
    check({tag, "_sin_a"}, 32'(sin_a), 32'(f_sin(p.a)));
    check({tag, "_cos_a"}, 32'(cos_a), 32'(f_cos(p.a)));
    check({tag, "_sin_b"}, 32'(sin_b), 32'(f_sin(p.b)));
    check({tag, "_cos_b"}, 32'(cos_b), 32'(f_cos(p.b)));
    check({tag, "_sin_g"}, 32'(sin_g), 32'(f_sin(p.g)));
    check({tag, "_cos_g"}, 32'(cos_g), 32'(f_cos(p.g)));
  endtask

  task automatic wait_frame_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      step();
      observe();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_frame_done_seen"}, 32'(seen), 32'd1);
  endtask

  // After frame_done: one cycle on, busy is low, exactly one pulse was seen and
  // every index 0..NV-1 was accepted exactly once, in order.
  task automatic finish_frame(input string tag, input int fd_before, input pose_t p);
    step();
    observe();
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_frame_done_count"}, 32'(fd_count - fd_before), 32'd1);
    check({tag, "_accept_count"}, 32'(got_q.size()), 32'(NV));
    for (int i = 0; i < NV && i < got_q.size(); i++)
      check({tag, "_index_order"}, 32'(got_q[i]), 32'(i));
    check_pose(tag, p);
    got_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    step();
    Reset = 1'b1;
    repeat (cycles) step();
    Reset = 1'b0;
  endtask

  initial begin
    pose_t p1, p2, p3;
    int fd0, k;

    do_reset(3);
    observe();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_xf_valid", 32'(xf_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_trig_angle", 32'(trig_angle), 32'd0);
    check("rst_sin_a", 32'(sin_a), 32'd0);
    check("rst_px", 32'(px), 32'd0);

    // Fixed angles; inputs are scrambled after the tick to prove the snapshot.
    p1 = rand_pose();
    p1.a = 12'h100; p1.b = 12'h200; p1.g = 12'h300;
    fd0 = fd_count;
    do_tick(p1);
    step(); tick = 1'b0; apply_pose(rand_pose()); observe();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_angle0", 32'(trig_angle), 32'h100);
    step(); observe();
    check("t1_angle1", 32'(trig_angle), 32'h200);
    step(); observe();
    check("t1_angle2", 32'(trig_angle), 32'h300);
    k = 3;
    while (k < 40 && xf_valid !== 1'b1) begin
      step(); observe(); k++;
    end
    check("t1_first_valid_cycle", 32'(k), 32'(FIRST_VALID));
    check("t1_first_index", 32'(xf_index), 32'd0);
    check_pose("t1_latched", p1);
    wait_frame_done("t1");
    finish_frame("t1", fd0, p1);

    // Random backpressure, random pose.
    rand_ready = 1'b1;
    p2 = rand_pose();
    fd0 = fd_count;
    do_tick(p2);
    step(); tick = 1'b0; apply_pose(rand_pose());
    wait_frame_done("t3");
    finish_frame("t3", fd0, p2);
    rand_ready = 1'b0;

    // Second tick during ISSUE: overrun, sequencing and snapshot untouched.
    p1 = rand_pose();
    fd0 = fd_count;
    do_tick(p1);
    step(); tick = 1'b0;
    repeat (FIRST_VALID) step();
    apply_pose(rand_pose());
    tick = 1'b1;
    observe();
    check("t4_in_issue", 32'(xf_valid), 32'd1);
    step(); tick = 1'b0; observe();
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_px_kept", 32'(px), 32'(p1.x));
    wait_frame_done("t4");
    finish_frame("t4", fd0, p1);
    check("t4_overrun_sticky", 32'(overrun), 32'd1);

    do_reset(2);
    observe();
    check("t5_overrun_cleared", 32'(overrun), 32'd0);

    // Full ready, completions two cycles after accept: accepts in cycles 6..9,
    // completions 8..11, so frame_done falls in cycle 11.
    p1 = rand_pose();
    p2 = rand_pose();
    fd0 = fd_count;
    do_tick(p1);
    step(); tick = 1'b0;
    repeat (10) step();
    apply_pose(p2);
    tick = 1'b1;
    observe();
    check("t5_frame_done_now", 32'(frame_done), 32'd1);
    check("t5_accepts", 32'(got_q.size()), 32'(NV));
    step(); tick = 1'b0; apply_pose(rand_pose()); observe();
    check("t5_overrun_zero", 32'(overrun), 32'd0);
    check("t5_busy_again", 32'(busy), 32'd1);
    check("t5_new_angle", 32'(trig_angle), 32'(p2.a));
    check("t5_one_done", 32'(fd_count - fd0), 32'd1);
    got_q.delete();
    fd0 = fd_count;
    wait_frame_done("t5b");
    finish_frame("t5b", fd0, p2);

    // Reset in DRAIN with two completions still outstanding.
    p3 = rand_pose();
    fd0 = fd_count;
    do_tick(p3);
    step(); tick = 1'b0;
    repeat (FIRST_VALID) step();
    tick = 1'b1;
    step(); tick = 1'b0;
    step();
    step();
    Reset = 1'b1;
    observe();
    check("t6_drain_busy", 32'(busy), 32'd1);
    check("t6_drain_valid", 32'(xf_valid), 32'd0);
    check("t6_drain_no_done", 32'(frame_done), 32'd0);
    check("t6_drain_overrun", 32'(overrun), 32'd1);
    step(); observe();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(xf_valid), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_px", 32'(px), 32'd0);
    check("t6_rst_sin_g", 32'(sin_g), 32'd0);
    check("t6_rst_frame_done", 32'(frame_done), 32'd0);
    step(); Reset = 1'b0;
    repeat (6) step();
    observe();
    check("t6_no_frame_done", 32'(fd_count - fd0), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    got_q.delete();

    // A clean frame afterwards must count completions from zero again.
    rand_ready = 1'b1;
    p3 = rand_pose();
    fd0 = fd_count;
    do_tick(p3);
    step(); tick = 1'b0;
    wait_frame_done("t7");
    finish_frame("t7", fd0, p3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, observed %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
